// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART-to-memory bridge.
// Holds FSM encodings, memory selectors and framing constants.
package uart_mem_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ_REQ  = 3'd2,
        S_READ_WAIT = 3'd3,
        S_LOAD      = 3'd4,
        S_SEND      = 3'd5,
        S_WAIT_TX   = 3'd6
    } state_e;

    localparam logic       MEM_IMEM         = 1'b0;
    localparam logic       MEM_DMEM         = 1'b1;
    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
    localparam int         BYTES_PER_WORD   = 4;

endpackage

// File: rtl/uart_mem_bridge_bits_tx.sv
// 8N1 UART transmitter, LSB first.
// start is accepted only while idle; busy covers the whole frame.
module uart_bits_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    // Frame sequencing: load {stop, data, start}, shift out one bit per period.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        if (!busy_q) begin
            if (start) begin
                frame_d = {1'b1, data, 1'b0};
                tx_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                busy_d  = 1'b1;
            end
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                frame_d = {1'b1, frame_q[9:1]};
                tx_d    = frame_q[1];
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// Executes received packets as single-word memory accesses and
// answers the host over UART: ACK for writes, 4 bytes MSB-first for reads.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] ACK_BYTE     = DEFAULT_ACK_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [31:0] rx_data,
    input  logic [8:0]  rx_addr,
    input  logic        rx_mem_type,
    input  logic        rx_rw,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        imem_we,
    output logic        dmem_we,
    output logic        imem_re,
    output logic        dmem_re,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] dmem_rdata,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    state_e      state_q, state_d;
    logic        type_q, type_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;
    logic        overrun_q, overrun_d;
    logic        tx_start;
    logic        tx_busy;

    // Next-state and datapath control for the access/response sequence.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        count_d   = count_q;
        overrun_d = overrun_q | (rx_done && state_q != S_IDLE);
        tx_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_done) begin
                    type_d  = rx_mem_type;
                    addr_d  = rx_addr;
                    wdata_d = rx_data;
                    state_d = rx_rw ? S_WRITE : S_READ_REQ;
                end
            end
            S_WRITE: begin
                shift_d = {ACK_BYTE, 24'h0};
                count_d = 3'd1;
                state_d = S_SEND;
            end
            S_READ_REQ: begin
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                shift_d = (type_q == MEM_DMEM) ? dmem_rdata : imem_rdata;
                count_d = 3'(BYTES_PER_WORD);
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (!tx_busy) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    count_d = count_q - 3'd1;
                    state_d = (count_q == 3'd1) ? S_IDLE : S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            type_q    <= MEM_IMEM;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign imem_we   = (state_q == S_WRITE)    && (type_q == MEM_IMEM);
    assign dmem_we   = (state_q == S_WRITE)    && (type_q == MEM_DMEM);
    assign imem_re   = (state_q == S_READ_REQ) && (type_q == MEM_IMEM);
    assign dmem_re   = (state_q == S_READ_REQ) && (type_q == MEM_DMEM);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

    uart_bits_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .start(tx_start),
        .data (shift_q[31:24]),
        .tx   (tx),
        .busy (tx_busy)
    );

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: memory model, UART frame decoder and
// expected-byte queue, plus timing and reset scenarios.
module tb_uart_mem_bridge;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_done;
    logic [31:0] rx_data;
    logic [8:0]  rx_addr;
    logic        rx_mem_type;
    logic        rx_rw;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        imem_we, dmem_we, imem_re, dmem_re;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        tx, busy, overrun;

    uart_mem_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .rx_addr    (rx_addr),
        .rx_mem_type(rx_mem_type),
        .rx_rw      (rx_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .imem_we    (imem_we),
        .dmem_we    (dmem_we),
        .imem_re    (imem_re),
        .dmem_re    (dmem_re),
        .imem_rdata (imem_rdata),
        .dmem_rdata (dmem_rdata),
        .tx         (tx),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory model: synchronous write, read data one cycle after strobe.
    logic [31:0] imem_m [512];
    logic [31:0] dmem_m [512];
    logic [31:0] ref_dmem [512];
    always @(posedge clk) begin
        if (imem_we) imem_m[mem_addr] <= mem_wdata;
        if (dmem_we) dmem_m[mem_addr] <= mem_wdata;
        if (imem_re) imem_rdata <= imem_m[mem_addr];
        if (dmem_re) dmem_rdata <= dmem_m[mem_addr];
    end

    // Strobe counters and multi-strobe detector.
    int n_iwe = 0, n_dwe = 0, n_ire = 0, n_dre = 0;
    bit multi_strobe = 1'b0;
    always @(negedge clk) begin
        if (imem_we === 1'b1) n_iwe++;
        if (dmem_we === 1'b1) n_dwe++;
        if (imem_re === 1'b1) n_ire++;
        if (dmem_re === 1'b1) n_dre++;
        if ($countones({imem_we, dmem_we, imem_re, dmem_re}) > 1)
            multi_strobe = 1'b1;
    end

    // Expected tx bytes and frame decoder.
    logic [7:0] exp_q[$];
    int         starts_q[$];
    int         frames_started = 0;
    logic [7:0] mon_b;
    logic       mon_stop;
    bit         mon_ab;
    int         mon_st;

    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                mon_st = cyc;
                mon_ab = 1'b0;
                mon_stop = 1'b0;
                frames_started++;
                for (int i = 0; i < 9 && !mon_ab; i++) begin
                    for (int k = 0; k < CPB; k++) begin
                        @(negedge clk);
                        if (reset !== 1'b0) mon_ab = 1'b1;
                    end
                    if (i < 8) mon_b[i] = tx;
                    else mon_stop = tx;
                end
                if (!mon_ab) begin
                    starts_q.push_back(mon_st);
                    check("stop_bit", {31'h0, mon_stop}, 32'h1);
                    if (exp_q.size() == 0)
                        check("tx_extra_byte", {24'h0, mon_b}, 32'hFFFF_FFFF);
                    else
                        check("tx_byte", {24'h0, mon_b}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic send_pkt(input logic t, input logic rw,
                            input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        rx_mem_type = t;
        rx_rw       = rw;
        rx_addr     = a;
        rx_data     = d;
        rx_done     = 1'b1;
        @(negedge clk);
        rx_done     = 1'b0;
    endtask

    task automatic wait_idle(output int fall);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", 32'h1, 32'h0);
        fall = cyc;
    endtask

    int fall, s0, s1, s2, s3, base, n;

    initial begin
        for (int i = 0; i < 512; i++) begin
            imem_m[i]   = 32'h0;
            dmem_m[i]   = 32'h0;
            ref_dmem[i] = 32'h0;
        end
        dmem_m[3]   = 32'h1234_5678;
        ref_dmem[3] = 32'h1234_5678;
        imem_rdata  = 32'h0;
        dmem_rdata  = 32'h0;
        reset       = 1'b1;
        rx_done     = 1'b0;
        rx_data     = 32'h0;
        rx_addr     = 9'h0;
        rx_mem_type = 1'b0;
        rx_rw       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_addr", {23'h0, mem_addr}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_strobes", {28'h0, imem_we, dmem_we, imem_re, dmem_re}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write dmem 012 <- DEADBEEF
        s0 = n_dwe;
        exp_q.push_back(8'hA5);
        send_pkt(1'b1, 1'b1, 9'h012, 32'hDEAD_BEEF);
        ref_dmem[9'h012] = 32'hDEAD_BEEF;
        check("wr_dwe_t1", {31'h0, dmem_we}, 32'h1);
        check("wr_addr", {23'h0, mem_addr}, 32'h012);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("wr_dwe_t2", {31'h0, dmem_we}, 32'h0);
        check("wr_tx_t2", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("wr_start_t3", {31'h0, tx}, 32'h0);
        wait_idle(fall);
        check("wr_dwe_count", n_dwe - s0, 32'd1);
        check("wr_ack_done", exp_q.size(), 32'd0);

        // Write imem 1FF
        s0 = n_iwe;
        s1 = n_dwe;
        exp_q.push_back(8'hA5);
        send_pkt(1'b0, 1'b1, 9'h1FF, 32'h0BAD_F00D);
        check("iwr_iwe_t1", {31'h0, imem_we}, 32'h1);
        wait_idle(fall);
        check("iwr_iwe_count", n_iwe - s0, 32'd1);
        check("iwr_dwe_none", n_dwe - s1, 32'd0);
        check("iwr_ack_done", exp_q.size(), 32'd0);

        // Read dmem 3
        s0 = n_dre;
        base = starts_q.size();
        push_word(ref_dmem[3]);
        send_pkt(1'b1, 1'b0, 9'h003, 32'h0);
        check("rd_dre_t1", {31'h0, dmem_re}, 32'h1);
        @(negedge clk);
        check("rd_tx_t2", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("rd_tx_t3", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("rd_start_t4", {31'h0, tx}, 32'h0);
        wait_idle(fall);
        check("rd_bytes_done", exp_q.size(), 32'd0);
        check("rd_frames", starts_q.size() - base, 32'd4);
        check("rd_dre_count", n_dre - s0, 32'd1);
        if (starts_q.size() - base == 4) begin
            for (int i = base; i < base + 3; i++) begin
                n = starts_q[i + 1] - starts_q[i];
                check("rd_gap", {31'h0, (n >= 10 * CPB && n <= 10 * CPB + 2)}, 32'h1);
            end
            n = fall - starts_q[base + 3];
            check("rd_busy_fall", {31'h0, (n == 10 * CPB || n == 10 * CPB + 1)}, 32'h1);
        end

        // Overrun during read transmission
        check("pre_overrun", {31'h0, overrun}, 32'h0);
        push_word(ref_dmem[3]);
        send_pkt(1'b1, 1'b0, 9'h003, 32'h0);
        repeat (20) @(negedge clk);
        s0 = n_iwe + n_dwe + n_ire + n_dre;
        send_pkt(1'b1, 1'b1, 9'h005, 32'h1111_1111);
        repeat (3) @(negedge clk);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        check("ovr_no_strobe", n_iwe + n_dwe + n_ire + n_dre - s0, 32'd0);
        wait_idle(fall);
        check("ovr_bytes_done", exp_q.size(), 32'd0);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);

        // Reset during 2nd byte of a read
        base = frames_started;
        push_word(ref_dmem[9'h012]);
        send_pkt(1'b1, 1'b0, 9'h012, 32'h0);
        n = 0;
        while (frames_started < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_byte2", {31'h0, (frames_started >= base + 2)}, 32'h1);
        @(posedge clk);
        #1;
        check("pre_reset_tx", {31'h0, tx}, 32'h0);
        reset = 1'b1;
        #1;
        check("async_rst_tx", {31'h0, tx}, 32'h1);
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("rst_clr_overrun", {31'h0, overrun}, 32'h0);
        repeat (2) @(negedge clk);

        // Write after reset
        s0 = n_dwe;
        exp_q.push_back(8'hA5);
        send_pkt(1'b1, 1'b1, 9'h007, 32'hABCD_0123);
        ref_dmem[9'h007] = 32'hABCD_0123;
        wait_idle(fall);
        check("post_rst_dwe", n_dwe - s0, 32'd1);
        check("post_rst_ack", exp_q.size(), 32'd0);

        // Back-to-back write then read of the same word
        s0 = n_dwe;
        s1 = n_dre;
        s2 = n_iwe;
        s3 = n_ire;
        exp_q.push_back(8'hA5);
        send_pkt(1'b1, 1'b1, 9'h040, 32'hCAFE_F00D);
        ref_dmem[9'h040] = 32'hCAFE_F00D;
        wait_idle(fall);
        push_word(ref_dmem[9'h040]);
        send_pkt(1'b1, 1'b0, 9'h040, 32'h0);
        wait_idle(fall);
        check("b2b_dwe", n_dwe - s0, 32'd1);
        check("b2b_dre", n_dre - s1, 32'd1);
        check("b2b_imem", (n_iwe - s2) + (n_ire - s3), 32'd0);
        check("b2b_bytes_done", exp_q.size(), 32'd0);

        check("multi_strobe", {31'h0, multi_strobe}, 32'h0);
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
